rc5_key_schedule_ctrl: RTL and testbench



---
 rtl/rc5_pkg.sv | 27 ++
 rtl/rc5_key_schedule_ctrl_if.sv | 31 +++
 rtl/rc5_rotl.sv | 12 +
 rtl/rc5_key_schedule_ctrl.sv | 153 +++++++++++++++
 tb/tb_rc5_key_schedule_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rc5_pkg.sv
// Shared RC5 key-schedule definitions: word width, magic constants,
// controller state encoding and the word rotate used by the datapath.
package rc5_pkg;

  localparam int W     = 32;
  localparam int AMT_W = $clog2(W);

  localparam logic [W-1:0] PW = 32'hB7E15163;
  localparam logic [W-1:0] QW = 32'h9E3779B9;

  typedef enum logic [2:0] {
    IDLE,
    INIT_S,
    MIX_RD,
    MIX_S,
    MIX_L,
    DONE
  } state_t;

  // The upper half of {x,x} shifted left is exactly x rotated left by amt.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [AMT_W-1:0] amt);
    logic [2*W-1:0] dbl;
    dbl = {x, x} << amt;
    return dbl[2*W-1:W];
  endfunction

endpackage

// File: rtl/rc5_key_schedule_ctrl_if.sv
// Handshake and S/L RAM port bundle between the key-schedule controller
// and its environment (key loader, RAMs, round engine).
interface rc5_key_schedule_ctrl_if #(
  parameter int W     = 32,
  parameter int T_LEN = 5,
  parameter int C_LEN = 2
);

  logic             start;
  logic             busy;
  logic             done;
  logic [T_LEN-1:0] s_addr;
  logic             s_we;
  logic [W-1:0]     s_wdata;
  logic [W-1:0]     s_rdata;
  logic [C_LEN-1:0] l_addr;
  logic             l_we;
  logic [W-1:0]     l_wdata;
  logic [W-1:0]     l_rdata;

  modport master (
    input  start, s_rdata, l_rdata,
    output busy, done, s_addr, s_we, s_wdata, l_addr, l_we, l_wdata
  );

  modport slave (
    output start, s_rdata, l_rdata,
    input  busy, done, s_addr, s_we, s_wdata, l_addr, l_we, l_wdata
  );

endinterface

// File: rtl/rc5_rotl.sv
// Combinational w-bit barrel rotate-left.
module rc5_rotl
  import rc5_pkg::*;
(
  input  logic [W-1:0]     x,
  input  logic [AMT_W-1:0] amt,
  output logic [W-1:0]     y
);

  assign y = rotl(x, amt);

endmodule

// File: rtl/rc5_key_schedule_ctrl.sv
// RC5 key expansion sequencer: fills S from Pw/Qw, then runs the
// 3*max(t,c) mixing loop over the S and L RAMs.
module rc5_key_schedule_ctrl
  import rc5_pkg::*;
#(
  parameter int           w  = W,
  parameter int           t  = 26,
  parameter int           c  = 4,
  parameter logic [w-1:0] Pw = PW,
  parameter logic [w-1:0] Qw = QW
) (
  input logic clk,
  input logic rst,
  rc5_key_schedule_ctrl_if.master bus
);

  localparam int t_length = (t > 1) ? $clog2(t) : 1;
  localparam int c_length = (c > 1) ? $clog2(c) : 1;
  localparam int n_mix    = 3 * ((t > c) ? t : c);
  localparam int k_length = (n_mix > 1) ? $clog2(n_mix) : 1;

  localparam logic [t_length-1:0] T_LAST = t_length'(t - 1);
  localparam logic [c_length-1:0] C_LAST = c_length'(c - 1);
  localparam logic [k_length-1:0] K_LAST = k_length'(n_mix - 1);

  state_t state, state_nxt;

  logic [t_length-1:0] i;
  logic [c_length-1:0] j;
  logic [k_length-1:0] k;
  logic [w-1:0]        acc;
  logic [w-1:0]        a_reg;
  logic [w-1:0]        b_reg;
  logic [w-1:0]        l_reg;

  logic [w-1:0]       a_sum, a_new;
  logic [w-1:0]       b_sum, b_new;
  logic [AMT_W-1:0]   rot_amt;

  // In MIX_L a_reg already holds the freshly written S word, as RC5 requires.
  assign a_sum   = bus.s_rdata + a_reg + b_reg;
  assign b_sum   = l_reg + a_reg + b_reg;
  assign rot_amt = a_reg[AMT_W-1:0] + b_reg[AMT_W-1:0];

  rc5_rotl u_rotl_a (
    .x   (a_sum),
    .amt (AMT_W'(3)),
    .y   (a_new)
  );

  rc5_rotl u_rotl_b (
    .x   (b_sum),
    .amt (rot_amt),
    .y   (b_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i     <= '0;
      j     <= '0;
      k     <= '0;
      acc   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      l_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= Pw;
            a_reg <= '0;
            b_reg <= '0;
          end
        end
        INIT_S: begin
          acc <= acc + Qw;
          i   <= (i == T_LAST) ? '0 : i + 1'b1;
        end
        MIX_S: begin
          a_reg <= a_new;
          l_reg <= bus.l_rdata;
        end
        MIX_L: begin
          b_reg <= b_new;
          i     <= (i == T_LAST) ? '0 : i + 1'b1;
          j     <= (j == C_LAST) ? '0 : j + 1'b1;
          k     <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    state_nxt   = state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.s_addr  = '0;
    bus.s_we    = 1'b0;
    bus.s_wdata = '0;
    bus.l_addr  = '0;
    bus.l_we    = 1'b0;
    bus.l_wdata = '0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = INIT_S;
      end
      INIT_S: begin
        bus.busy    = 1'b1;
        bus.s_we    = 1'b1;
        bus.s_addr  = i;
        bus.s_wdata = acc;
        if (i == T_LAST) state_nxt = MIX_RD;
      end
      MIX_RD: begin
        bus.busy   = 1'b1;
        bus.s_addr = i;
        bus.l_addr = j;
        state_nxt  = MIX_S;
      end
      MIX_S: begin
        bus.busy    = 1'b1;
        bus.s_we    = 1'b1;
        bus.s_addr  = i;
        bus.s_wdata = a_new;
        bus.l_addr  = j;
        state_nxt   = MIX_L;
      end
      MIX_L: begin
        bus.busy    = 1'b1;
        bus.l_we    = 1'b1;
        bus.l_addr  = j;
        bus.l_wdata = b_new;
        state_nxt   = (k == K_LAST) ? DONE : MIX_RD;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc5_key_schedule_ctrl.sv
// Directed bench for rc5_key_schedule_ctrl: default t=26/c=4 instance plus a
// t=4/c=8 instance, each backed by simple synchronous-read RAM models.
module tb_rc5_key_schedule_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rc5_key_schedule_ctrl_if #(.W(32), .T_LEN(5), .C_LEN(2)) bus0 ();
  rc5_key_schedule_ctrl_if #(.W(32), .T_LEN(2), .C_LEN(3)) bus1 ();

  rc5_key_schedule_ctrl #(.t(26), .c(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  rc5_key_schedule_ctrl #(.t(4), .c(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic [31:0] s_mem0 [32];
  logic [31:0] l_mem0 [4];
  logic [31:0] s_mem1 [4];
  logic [31:0] l_mem1 [8];

  logic        ld_en0, ld_en1;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;

  logic [31:0] key_l [8];
  logic [31:0] exp_s [32];
  logic [31:0] exp_l [8];

  int checks   = 0;
  int failures = 0;
  int done_n;
  int lwe_cnt;

  // RAM models: one-cycle read latency; the bench loads L through a side port.
  always @(posedge clk) begin
    if (bus0.s_we) s_mem0[bus0.s_addr] <= bus0.s_wdata;
    bus0.s_rdata <= s_mem0[bus0.s_addr];
    if (ld_en0) l_mem0[ld_addr[1:0]] <= ld_data;
    else if (bus0.l_we) l_mem0[bus0.l_addr] <= bus0.l_wdata;
    bus0.l_rdata <= l_mem0[bus0.l_addr];
  end

  always @(posedge clk) begin
    if (bus1.s_we) s_mem1[bus1.s_addr] <= bus1.s_wdata;
    bus1.s_rdata <= s_mem1[bus1.s_addr];
    if (ld_en1) l_mem1[ld_addr] <= ld_data;
    else if (bus1.l_we) l_mem1[bus1.l_addr] <= bus1.l_wdata;
    bus1.l_rdata <= l_mem1[bus1.l_addr];
  end

  function automatic logic [31:0] rotl_ref(input logic [31:0] x, input int n);
    logic [31:0] v;
    v = x;
    for (int q = 0; q < n; q++) v = {v[30:0], v[31]};
    return v;
  endfunction

  // Straight transcription of the RC5 reference key expansion.
  task automatic run_model(input int tt, input int cc);
    logic [31:0] a, b;
    int ii, jj, nn;
    exp_s[0] = 32'hB7E15163;
    for (int x = 1; x < tt; x++) exp_s[x] = exp_s[x-1] + 32'h9E3779B9;
    for (int x = 0; x < cc; x++) exp_l[x] = key_l[x];
    a = 0; b = 0; ii = 0; jj = 0;
    nn = 3 * ((tt > cc) ? tt : cc);
    for (int kk = 0; kk < nn; kk++) begin
      a = rotl_ref(exp_s[ii] + a + b, 3);
      exp_s[ii] = a;
      b = rotl_ref(exp_l[jj] + a + b, int'((a + b) & 32'd31));
      exp_l[jj] = b;
      ii = (ii + 1) % tt;
      jj = (jj + 1) % cc;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input int which, input int cc);
    for (int x = 0; x < cc; x++) begin
      @(negedge clk);
      if (which == 0) ld_en0 = 1'b1; else ld_en1 = 1'b1;
      ld_addr = 3'(x);
      ld_data = key_l[x];
    end
    @(negedge clk);
    ld_en0 = 1'b0;
    ld_en1 = 1'b0;
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  // Counts cycles from n_start to the done pulse; optionally pokes start at n=100.
  task automatic wait_done(input int which, input int n_start, input bit poke,
                           output int dn, output int lwe);
    int n;
    n = n_start; dn = -1; lwe = 0;
    while (n < 400) begin
      if (((which == 0) ? bus0.done : bus1.done) === 1'b1) begin
        dn = n;
        break;
      end
      if (((which == 0) ? bus0.l_we : bus1.l_we) === 1'b1) lwe++;
      bus0.start = (which == 0) && poke && (n == 100);
      @(negedge clk);
      n++;
    end
    bus0.start = 1'b0;
  endtask

  task automatic check_contents(input int which, input int tt, input int cc, input string tag);
    for (int x = 0; x < tt; x++)
      check_output($sformatf("%s_S%0d", tag, x), (which == 0) ? s_mem0[x] : s_mem1[x], exp_s[x]);
    for (int x = 0; x < cc; x++)
      check_output($sformatf("%s_L%0d", tag, x), (which == 0) ? l_mem0[x] : l_mem1[x], exp_l[x]);
  endtask

  initial begin
    rst = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    ld_en0 = 1'b0; ld_en1 = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);

    check_output("rst_busy",   32'(bus0.busy),   32'd0);
    check_output("rst_done",   32'(bus0.done),   32'd0);
    check_output("rst_s_we",   32'(bus0.s_we),   32'd0);
    check_output("rst_l_we",   32'(bus0.l_we),   32'd0);
    check_output("rst_s_addr", 32'(bus0.s_addr), 32'd0);
    check_output("rst_l_addr", 32'(bus0.l_addr), 32'd0);
    check_output("rst_s_wdata", bus0.s_wdata,    32'd0);
    rst = 1'b0;

    $display("[TB] run 1: all-zero key, directed first writes");
    for (int x = 0; x < 8; x++) key_l[x] = 32'h0;
    load_key(0, 4);
    pulse_start(0);
    check_output("init0_busy",  32'(bus0.busy),   32'd1);
    check_output("init0_we",    32'(bus0.s_we),   32'd1);
    check_output("init0_addr",  32'(bus0.s_addr), 32'd0);
    check_output("init0_data",  bus0.s_wdata,     32'hB7E15163);
    @(negedge clk);
    check_output("init1_addr",  32'(bus0.s_addr), 32'd1);
    check_output("init1_data",  bus0.s_wdata,     32'h5618CB1C);
    @(negedge clk);
    check_output("init2_addr",  32'(bus0.s_addr), 32'd2);
    check_output("init2_data",  bus0.s_wdata,     32'hF45044D5);
    repeat (24) @(negedge clk);
    check_output("mixrd_s_we",  32'(bus0.s_we),   32'd0);
    check_output("mixrd_l_we",  32'(bus0.l_we),   32'd0);
    @(negedge clk);
    check_output("mixs_we",     32'(bus0.s_we),   32'd1);
    check_output("mixs_addr",   32'(bus0.s_addr), 32'd0);
    check_output("mixs_data",   bus0.s_wdata,     32'hBF0A8B1D);
    @(negedge clk);
    check_output("mixl_we",     32'(bus0.l_we),   32'd1);
    check_output("mixl_addr",   32'(bus0.l_addr), 32'd0);
    check_output("mixl_data",   bus0.l_wdata,     32'hB7E15163);
    @(negedge clk);
    wait_done(0, 30, 1'b0, done_n, lwe_cnt);
    check_output("run1_latency", 32'(done_n), 32'd261);
    check_output("run1_done_busy", 32'(bus0.busy), 32'd0);
    @(negedge clk);
    check_output("run1_done_pulse", 32'(bus0.done), 32'd0);
    run_model(26, 4);
    check_contents(0, 26, 4, "run1");

    $display("[TB] run 2: byte-ramp key, start poked while busy and in DONE");
    key_l[0] = 32'h03020100; key_l[1] = 32'h07060504;
    key_l[2] = 32'h0B0A0908; key_l[3] = 32'h0F0E0D0C;
    load_key(0, 4);
    pulse_start(0);
    wait_done(0, 1, 1'b1, done_n, lwe_cnt);
    check_output("run2_latency", 32'(done_n), 32'd261);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    check_output("run2_post_busy", 32'(bus0.busy), 32'd0);
    check_output("run2_post_done", 32'(bus0.done), 32'd0);
    @(negedge clk);
    check_output("run2_idle_busy", 32'(bus0.busy), 32'd0);
    run_model(26, 4);
    check_contents(0, 26, 4, "run2");

    $display("[TB] run 3: reset during mix iteration 40");
    load_key(0, 4);
    pulse_start(0);
    repeat (147) @(negedge clk);
    check_output("k40_s_we",   32'(bus0.s_we),   32'd1);
    check_output("k40_s_addr", 32'(bus0.s_addr), 32'd14);
    #1 rst = 1'b1;
    #1;
    check_output("abort_s_we", 32'(bus0.s_we), 32'd0);
    check_output("abort_l_we", 32'(bus0.l_we), 32'd0);
    check_output("abort_busy", 32'(bus0.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] run 4: restart after abort with reloaded key");
    load_key(0, 4);
    pulse_start(0);
    wait_done(0, 1, 1'b0, done_n, lwe_cnt);
    check_output("run4_latency", 32'(done_n), 32'd261);
    run_model(26, 4);
    check_contents(0, 26, 4, "run4");

    $display("[TB] run 5: t=4 c=8 instance");
    key_l[0] = 32'h01234567; key_l[1] = 32'h89ABCDEF;
    key_l[2] = 32'h00000000; key_l[3] = 32'hFFFFFFFF;
    key_l[4] = 32'hDEADBEEF; key_l[5] = 32'h12345678;
    key_l[6] = 32'h0F0F0F0F; key_l[7] = 32'h80000000;
    load_key(1, 8);
    pulse_start(1);
    wait_done(1, 1, 1'b0, done_n, lwe_cnt);
    check_output("run5_latency", 32'(done_n),  32'd77);
    check_output("run5_l_writes", 32'(lwe_cnt), 32'd24);
    run_model(4, 8);
    check_contents(1, 4, 8, "run5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
